// File: rtl/bitty_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bitty_fetch_sequencer
//  Description : Instruction sequencer for bitty_core. Fetches 16-bit words
//                from a synchronous-read instruction memory, issues each one
//                to the core with a single-cycle run pulse, waits for done,
//                then advances the PC. Stops on a halt word, the last
//                address, a stop request or a watchdog timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitty_fetch_sequencer #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [15:0] HALT_WORD   = 16'hFFFF,
    parameter int          WDOG_CYCLES = 64,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  stop,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [15:0]           mem_rdata,
    output logic                  run,
    output logic [15:0]           instruction,
    input  logic                  done,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  halted,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  retired
);

    // Watchdog is wide enough to hold WDOG_CYCLES-1 with a spare bit.
    localparam int c_wdog_w = $clog2(WDOG_CYCLES) + 1;

    // The watchdog trips on the EXEC cycle whose increment would make it reach
    // WDOG_CYCLES-1, so ERROR is entered WDOG_CYCLES cycles after the run pulse.
    localparam logic [c_wdog_w-1:0]   c_wdog_trip = c_wdog_w'(WDOG_CYCLES - 2);
    localparam logic [ADDR_WIDTH-1:0] c_pc_last   = {ADDR_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  c_cnt_max   = {CNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_ISSUE   = 3'd3,
        S_EXEC    = 3'd4,
        S_ADVANCE = 3'd5,
        S_HALT    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [15:0]             r_instruction;
    logic [CNT_WIDTH-1:0]    r_retired;
    logic [c_wdog_w-1:0]     r_wdog;
    logic                    r_stop_latched;

    logic                    w_resting;
    logic                    w_busy;
    logic                    w_start_accept;
    logic                    w_halt_word;
    logic                    w_stop_req;
    logic                    w_pc_at_end;
    logic                    w_wdog_expired;

    // Decoded conditions shared by the next-state logic and the datapath.
    always_comb begin
        w_resting      = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERROR);
        w_busy         = !w_resting;
        w_start_accept = w_resting && start;
        w_halt_word    = (mem_rdata == HALT_WORD);
        w_stop_req     = stop || r_stop_latched;
        w_pc_at_end    = (r_pc == c_pc_last);
        w_wdog_expired = (r_wdog == c_wdog_trip);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one fetch/issue/execute/advance loop per instruction.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_HALT, S_ERROR: begin
                // start has priority over a coincident stop; stop is ignored here
                if (start) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // read data is valid exactly one cycle after the strobe
                if (w_halt_word) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                if (done) begin
                    w_next_state = S_ADVANCE;
                end else if (w_wdog_expired) begin
                    w_next_state = S_ERROR;
                end
            end
            S_ADVANCE: begin
                // the last address ends the program rather than wrapping to 0
                if (w_stop_req || w_pc_at_end) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Program counter: loaded on start, incremented only on a non-final advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else if (w_start_accept) begin
            r_pc <= start_addr;
        end else if ((r_state == S_ADVANCE) && !w_stop_req && !w_pc_at_end) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    // Instruction register: captures every non-halt word and holds it
    // through EXEC and afterwards (including in ERROR).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instruction <= '0;
        end else if ((r_state == S_WAIT) && !w_halt_word) begin
            r_instruction <= mem_rdata;
        end
    end

    // Retired counter: cleared on start, saturating increment per completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_start_accept) begin
            r_retired <= '0;
        end else if ((r_state == S_ADVANCE) && (r_retired != c_cnt_max)) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    // Watchdog: restarted on issue, counts EXEC cycles that see no done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wdog <= '0;
        end else if ((r_state == S_EXEC) && !done && !w_wdog_expired) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Stop latch: remembers a stop seen mid-instruction until the next
    // boundary; a fresh start also discards any stale request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stop_latched <= 1'b0;
        end else if (w_next_state == S_HALT) begin
            r_stop_latched <= 1'b0;
        end else if (w_busy && stop) begin
            r_stop_latched <= 1'b1;
        end else if (w_start_accept) begin
            r_stop_latched <= 1'b0;
        end
    end

    // Output decode: strobes come straight from state so each is one cycle wide.
    always_comb begin
        mem_rd      = (r_state == S_FETCH);
        mem_addr    = r_pc;
        run         = (r_state == S_ISSUE);
        instruction = r_instruction;
        pc          = r_pc;
        busy        = w_busy;
        halted      = (r_state == S_HALT);
        error       = (r_state == S_ERROR);
        retired     = r_retired;
    end

endmodule
`default_nettype wire

// File: tb/tb_bitty_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitty_fetch_sequencer
//  Description : Directed self-checking bench for bitty_fetch_sequencer with
//                a synchronous memory model and a simple core done model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitty_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic        stop;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        run;
    logic [15:0] instruction;
    logic        done;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        error;
    logic [15:0] retired;

    // second instance with a 2-bit address space
    logic        start2;
    logic [1:0]  start_addr2;
    logic        mem_rd2;
    logic [1:0]  mem_addr2;
    logic [15:0] mem_rdata2;
    logic        run2;
    logic [15:0] instruction2;
    logic        done2;
    logic [1:0]  pc2;
    logic        busy2;
    logic        halted2;
    logic        error2;
    logic [15:0] retired2;

    logic [15:0] mem  [0:255];
    logic [15:0] mem2 [0:3];

    int          cyc = 0;
    int          done_delay = 2;
    int          dcnt = 0;
    int          rd_cyc[$];
    int          run_cyc[$];
    logic [15:0] run_ins[$];
    int          n_run2 = 0;
    int          n_rd2  = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    bitty_fetch_sequencer #(
        .ADDR_WIDTH(8), .HALT_WORD(16'hFFFF), .WDOG_CYCLES(64), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stop(stop),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .run(run), .instruction(instruction), .done(done), .pc(pc),
        .busy(busy), .halted(halted), .error(error), .retired(retired)
    );

    bitty_fetch_sequencer #(
        .ADDR_WIDTH(2), .HALT_WORD(16'hFFFF), .WDOG_CYCLES(64), .CNT_WIDTH(16)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start2), .start_addr(start_addr2), .stop(1'b0),
        .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
        .run(run2), .instruction(instruction2), .done(done2), .pc(pc2),
        .busy(busy2), .halted(halted2), .error(error2), .retired(retired2)
    );

    always #5 clk = ~clk;

    // cycle index used to timestamp strobes
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read memories
    always @(posedge clk) begin
        if (mem_rd)  mem_rdata  <= mem[mem_addr];
        if (mem_rd2) mem_rdata2 <= mem2[mem_addr2];
    end

    // core model: done is high exactly done_delay cycles after run (0 = never)
    always @(posedge clk) begin
        if (run) begin
            dcnt <= (done_delay > 0) ? done_delay - 1 : 0;
            done <= (done_delay == 1);
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            done <= (dcnt == 1);
        end else begin
            done <= 1'b0;
        end
        done2 <= run2;
    end

    // strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd) rd_cyc.push_back(cyc);
            if (run) begin
                run_cyc.push_back(cyc);
                run_ins.push_back(instruction);
            end
            if (run2)    n_run2 = n_run2 + 1;
            if (mem_rd2) n_rd2  = n_rd2 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rd_cyc.delete();
        run_cyc.delete();
        run_ins.delete();
    endtask

    task automatic do_start(input logic [7:0] a, output int t);
        start      = 1'b1;
        start_addr = a;
        t          = cyc;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // returns positioned in the cycle after the run pulse at address a (EXEC)
    task automatic wait_run_pc(input string tag, input logic [7:0] a, input int budget);
        logic found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (run && pc == a) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, found}, 32'd1);
        tick(1);
    endtask

    initial begin
        int t;
        int ec;
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        for (int i = 0; i < 4; i++)   mem2[i] = 16'h0001;
        reset = 1'b1; start = 1'b0; stop = 1'b0; start_addr = '0;
        start2 = 1'b0; start_addr2 = '0;
        tick(3);

        // reset state
        check("rst_run",    {31'd0, run}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_instr",  {16'd0, instruction}, 32'd0);
        check("rst_pc",     {24'd0, pc}, 32'd0);
        check("rst_flags",  {29'd0, busy, halted, error}, 32'd0);
        check("rst_retired",{16'd0, retired}, 32'd0);
        reset = 1'b0;
        tick(2);

        // 1: two instructions then halt word
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hFFFF;
        done_delay = 2;
        clear_log();
        do_start(8'd0, t);
        wait_not_busy("t1_timeout", 60);
        check("t1_run_count", run_cyc.size(), 32'd2);
        check("t1_instr0",    {16'd0, run_ins[0]}, 32'h1234);
        check("t1_instr1",    {16'd0, run_ins[1]}, 32'h5678);
        check("t1_halted",    {31'd0, halted}, 32'd1);
        check("t1_retired",   {16'd0, retired}, 32'd2);
        check("t1_pc",        {24'd0, pc}, 32'd2);

        // 2: latency start -> mem_rd -> run -> next mem_rd
        mem[0] = 16'h0001; mem[1] = 16'hFFFF;
        clear_log();
        do_start(8'd0, t);
        wait_not_busy("t2_timeout", 60);
        check("t2_rd0_cycle",  rd_cyc[0] - t, 32'd1);
        check("t2_run_cycle",  run_cyc[0] - t, 32'd3);
        check("t2_rd1_cycle",  rd_cyc[1] - t, 32'd7);
        check("t2_pc",         {24'd0, pc}, 32'd1);
        check("t2_retired",    {16'd0, retired}, 32'd1);

        // 3: watchdog expiry, then restart out of ERROR
        mem[0] = 16'h0ABC; mem[1] = 16'hFFFF;
        done_delay = 0;
        clear_log();
        do_start(8'd0, t);
        ec = -1;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (error) begin
                ec = cyc;
                break;
            end
        end
        check("t3_error",      {31'd0, error}, 32'd1);
        check("t3_wdog_late",  {31'd0, (ec - run_cyc[0]) <= 64}, 32'd1);
        check("t3_wdog_early", {31'd0, (ec - run_cyc[0]) >= 63}, 32'd1);
        tick(3);
        check("t3_run_count",  run_cyc.size(), 32'd1);
        check("t3_pc",         {24'd0, pc}, 32'd0);
        check("t3_instr_held", {16'd0, instruction}, 32'h0ABC);
        check("t3_busy",       {31'd0, busy}, 32'd0);
        done_delay = 2;
        clear_log();
        do_start(8'd0, t);
        check("t3_error_clr",  {31'd0, error}, 32'd0);
        check("t3_refetch",    {31'd0, mem_rd}, 32'd1);
        wait_not_busy("t3_timeout", 60);
        check("t3_retired",    {16'd0, retired}, 32'd1);

        // 4: stop during EXEC of the instruction at pc=3
        for (int i = 0; i < 7; i++) mem[i] = 16'h0010 + 16'(i);
        mem[7] = 16'hFFFF;
        done_delay = 3;
        clear_log();
        do_start(8'd0, t);
        wait_run_pc("t4_reach_pc3", 8'd3, 80);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_not_busy("t4_timeout", 60);
        tick(10);
        check("t4_halted",   {31'd0, halted}, 32'd1);
        check("t4_pc",       {24'd0, pc}, 32'd3);
        check("t4_retired",  {16'd0, retired}, 32'd4);
        check("t4_rd_count", rd_cyc.size(), 32'd4);

        // 5: last address of a 2-bit space halts without wrapping
        mem2[3] = 16'h0042;
        start2 = 1'b1; start_addr2 = 2'd3;
        tick(1);
        start2 = 1'b0;
        for (int k = 0; k < 40 && busy2; k++) tick(1);
        tick(5);
        check("t5_busy",     {31'd0, busy2}, 32'd0);
        check("t5_halted",   {31'd0, halted2}, 32'd1);
        check("t5_retired",  {16'd0, retired2}, 32'd1);
        check("t5_pc",       {30'd0, pc2}, 32'd3);
        check("t5_run_count", n_run2, 32'd1);
        check("t5_rd_count",  n_rd2, 32'd1);

        // 6: reset while an instruction is executing
        mem[4] = 16'h0111; mem[5] = 16'h0777; mem[6] = 16'hFFFF;
        done_delay = 2;
        clear_log();
        do_start(8'd4, t);
        wait_run_pc("t6_reach_pc5", 8'd5, 60);
        check("t6_pre_retired", {16'd0, retired}, 32'd1);
        reset = 1'b1;
        tick(1);
        check("t6_run",     {31'd0, run}, 32'd0);
        check("t6_instr",   {16'd0, instruction}, 32'd0);
        check("t6_pc",      {24'd0, pc}, 32'd0);
        check("t6_retired", {16'd0, retired}, 32'd0);
        check("t6_flags",   {29'd0, busy, halted, error}, 32'd0);
        reset = 1'b0;
        tick(2);

        // 7: start and stop together in IDLE -> start wins, stop ignored
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hFFFF;
        clear_log();
        stop = 1'b1;
        do_start(8'd0, t);
        stop = 1'b0;
        wait_not_busy("t7_timeout", 60);
        check("t7_retired", {16'd0, retired}, 32'd2);
        check("t7_pc",      {24'd0, pc}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // absolute time limit so a stuck run still terminates
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
